// File: rtl/kdf_lfsr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kdf_lfsr_pkg : FSM encoding, default LFSR constants, one-step helper |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package kdf_lfsr_pkg;

  // Widest LFSR the shared step helper supports.
  localparam int          c_lfsr_max_w   = 64;
  localparam logic [31:0] c_default_taps = 32'h80200003;
  localparam logic [31:0] c_default_init = 32'h00000001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ABSORB = 3'd2,
    ST_WARMUP = 3'd3,
    ST_RUN    = 3'd4
  } fsm_e;

  // Fibonacci step on a zero-extended state; in_bit is folded into the new MSB.
  function automatic logic [c_lfsr_max_w-1:0] lfsr_step(
    input logic [c_lfsr_max_w-1:0] state,
    input logic [c_lfsr_max_w-1:0] taps,
    input int unsigned             width,
    input logic                    in_bit
  );
    logic fb;
    fb = (^(state & taps)) ^ in_bit;
    return (state >> 1) | ({{(c_lfsr_max_w-1){1'b0}}, fb} << (width - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_unroll.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lfsr_unroll : combinational OUT_W-step LFSR advance with output bits |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lfsr_unroll
  import kdf_lfsr_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(c_default_taps),
  parameter int                OUT_W  = 8
) (
  input  logic [LFSR_W-1:0] state,
  output logic [LFSR_W-1:0] next_state,
  output logic [OUT_W-1:0]  bits
);

  logic [LFSR_W-1:0] w_chain [OUT_W+1];

  assign w_chain[0] = state;

  for (genvar j = 0; j < OUT_W; j++) begin : g_step
    assign bits[j]      = w_chain[j][0];
    assign w_chain[j+1] = LFSR_W'(lfsr_step(c_lfsr_max_w'(w_chain[j]),
                                            c_lfsr_max_w'(TAPS), LFSR_W, 1'b0));
  end

  assign next_state = w_chain[OUT_W];

endmodule
`default_nettype wire

// File: rtl/kdf_lfsr_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | kdf_lfsr_stream : seed-absorbing LFSR keystream generator, len-bound |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module kdf_lfsr_stream
  import kdf_lfsr_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(c_default_taps),
  parameter logic [LFSR_W-1:0] INIT   = LFSR_W'(c_default_init),
  parameter int                SEED_W = 256,
  parameter int                OUT_W  = 8,
  parameter int                WARMUP = 0,
  parameter int                LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [SEED_W-1:0] seed_data,
  input  logic [LEN_W-1:0]  len_words,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              done,
  output logic              zero_fix
);

  localparam int c_abs_cyc  = SEED_W - LFSR_W;
  localparam int c_step_max = (c_abs_cyc > WARMUP) ? c_abs_cyc : WARMUP;
  localparam int c_cnt_w    = $clog2(c_step_max + 2);

  fsm_e              r_fsm,       w_fsm_next;
  logic [LFSR_W-1:0] r_lfsr,      w_lfsr_next;
  // One pad bit above the seed keeps r_seed[LFSR_W] legal when SEED_W == LFSR_W.
  logic [SEED_W:0]   r_seed,      w_seed_next;
  logic [LEN_W-1:0]  r_len,       w_len_next;
  logic [LEN_W-1:0]  r_cnt,       w_cnt_next;
  logic [c_cnt_w-1:0] r_step,     w_step_next;
  logic              r_out_valid, w_valid_next;
  logic [OUT_W-1:0]  r_out_data,  w_data_next;
  logic              r_done,      w_done_next;
  logic              r_zero_fix,  w_zero_fix_next;
  logic              w_seeded;
  logic [LFSR_W-1:0] w_unroll_state;
  logic [OUT_W-1:0]  w_unroll_bits;

  lfsr_unroll #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .OUT_W  (OUT_W)
  ) u_unroll (
    .state      (r_lfsr),
    .next_state (w_unroll_state),
    .bits       (w_unroll_bits)
  );

  always_comb begin
    w_fsm_next      = r_fsm;
    w_lfsr_next     = r_lfsr;
    w_seed_next     = r_seed;
    w_len_next      = r_len;
    w_cnt_next      = r_cnt;
    w_step_next     = r_step;
    w_valid_next    = r_out_valid;
    w_data_next     = r_out_data;
    w_done_next     = 1'b0;
    w_zero_fix_next = r_zero_fix;
    w_seeded        = 1'b0;

    case (r_fsm)
      ST_IDLE: begin
        if (seed_valid) begin
          w_seed_next     = {1'b0, seed_data};
          w_len_next      = len_words;
          w_cnt_next      = '0;
          w_step_next     = '0;
          w_zero_fix_next = 1'b0;
          w_fsm_next      = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_lfsr_next = r_seed[LFSR_W-1:0];
        if (c_abs_cyc == 0) w_seeded = 1'b1;
        else                w_fsm_next = ST_ABSORB;
      end
      ST_ABSORB: begin
        w_lfsr_next = LFSR_W'(lfsr_step(c_lfsr_max_w'(r_lfsr), c_lfsr_max_w'(TAPS),
                                        LFSR_W, r_seed[LFSR_W]));
        w_seed_next = r_seed >> 1;
        w_step_next = r_step + c_cnt_w'(1);
        if (r_step == c_cnt_w'(c_abs_cyc - 1)) w_seeded = 1'b1;
      end
      ST_WARMUP: begin
        w_lfsr_next = LFSR_W'(lfsr_step(c_lfsr_max_w'(r_lfsr), c_lfsr_max_w'(TAPS),
                                        LFSR_W, 1'b0));
        w_step_next = r_step + c_cnt_w'(1);
        if (r_step == c_cnt_w'(WARMUP - 1)) begin
          if (r_len == '0) begin
            w_fsm_next  = ST_IDLE;
            w_done_next = 1'b1;
          end else begin
            w_fsm_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (!r_out_valid || out_ready) begin
          if (r_cnt != r_len) begin
            w_lfsr_next  = w_unroll_state;
            w_data_next  = w_unroll_bits;
            w_valid_next = 1'b1;
            w_cnt_next   = r_cnt + LEN_W'(1);
          end else begin
            // Only reachable once the final word has just been accepted.
            w_valid_next = 1'b0;
            w_done_next  = 1'b1;
            w_fsm_next   = ST_IDLE;
          end
        end
      end
      default: w_fsm_next = ST_IDLE;
    endcase

    if (w_seeded) begin
      w_step_next = '0;
      if (w_lfsr_next == '0) begin
        w_lfsr_next     = INIT;
        w_zero_fix_next = 1'b1;
      end
      if (WARMUP > 0) begin
        w_fsm_next = ST_WARMUP;
      end else if (r_len == '0) begin
        w_fsm_next  = ST_IDLE;
        w_done_next = 1'b1;
      end else begin
        w_fsm_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= ST_IDLE;
      r_lfsr      <= INIT;
      r_seed      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_step      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
      r_zero_fix  <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_next;
      r_lfsr      <= w_lfsr_next;
      r_seed      <= w_seed_next;
      r_len       <= w_len_next;
      r_cnt       <= w_cnt_next;
      r_step      <= w_step_next;
      r_out_valid <= w_valid_next;
      r_out_data  <= w_data_next;
      r_done      <= w_done_next;
      r_zero_fix  <= w_zero_fix_next;
    end
  end

  assign seed_ready = (r_fsm == ST_IDLE);
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign done       = r_done;
  assign zero_fix   = r_zero_fix;

endmodule
`default_nettype wire

// File: tb/tb_kdf_lfsr_stream.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_kdf_lfsr_stream : directed bench over three generator configs     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_kdf_lfsr_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [255:0] seed_bus;
  logic [15:0]  len_bus;
  logic         out_ready;
  logic         sv_s, sv_b, sv_w;
  logic         sr_s, ov_s, dn_s, zf_s;
  logic         sr_b, ov_b, dn_b, zf_b;
  logic         sr_w, ov_w, dn_w, zf_w;
  logic [7:0]   od_s, od_b;
  logic [4:0]   od_w;

  int errors = 0;
  int checks = 0;

  // Instance 0: 32-bit seed, no absorb; 1: defaults; 2: 16-bit LFSR with warm-up.
  kdf_lfsr_stream #(.SEED_W(32), .OUT_W(8), .WARMUP(0)) u_small (
    .clk(clk), .rst(rst), .seed_valid(sv_s), .seed_ready(sr_s),
    .seed_data(seed_bus[31:0]), .len_words(len_bus), .out_valid(ov_s),
    .out_ready(out_ready), .out_data(od_s), .done(dn_s), .zero_fix(zf_s));

  kdf_lfsr_stream u_big (
    .clk(clk), .rst(rst), .seed_valid(sv_b), .seed_ready(sr_b),
    .seed_data(seed_bus), .len_words(len_bus), .out_valid(ov_b),
    .out_ready(out_ready), .out_data(od_b), .done(dn_b), .zero_fix(zf_b));

  kdf_lfsr_stream #(.LFSR_W(16), .TAPS(16'hB400), .INIT(16'hACE1), .SEED_W(24),
                    .OUT_W(5), .WARMUP(3), .LEN_W(8)) u_warm (
    .clk(clk), .rst(rst), .seed_valid(sv_w), .seed_ready(sr_w),
    .seed_data(seed_bus[23:0]), .len_words(len_bus[7:0]), .out_valid(ov_w),
    .out_ready(out_ready), .out_data(od_w), .done(dn_w), .zero_fix(zf_w));

  int          cfg_lw   [3] = '{32, 32, 16};
  int          cfg_sw   [3] = '{32, 256, 24};
  int          cfg_ow   [3] = '{8, 8, 5};
  int          cfg_wu   [3] = '{0, 0, 3};
  logic [63:0] cfg_taps [3] = '{64'h80200003, 64'h80200003, 64'hB400};
  logic [63:0] cfg_init [3] = '{64'h1, 64'h1, 64'hACE1};

  int         sel = 0;
  logic       cur_ready, cur_valid, cur_done, cur_zf;
  logic [7:0] cur_data;

  always_comb begin
    cur_ready = sr_s; cur_valid = ov_s; cur_done = dn_s; cur_zf = zf_s; cur_data = od_s;
    case (sel)
      1: begin cur_ready = sr_b; cur_valid = ov_b; cur_done = dn_b; cur_zf = zf_b; cur_data = od_b; end
      2: begin cur_ready = sr_w; cur_valid = ov_w; cur_done = dn_w; cur_zf = zf_w; cur_data = {3'b000, od_w}; end
      default: ;
    endcase
  end

  logic [63:0] m_st;
  logic        m_zf;
  logic [7:0]  got [$];

  function automatic logic [63:0] m_step(input logic [63:0] st, input int s, input logic in_bit);
    logic        fb;
    logic [63:0] nst;
    fb = in_bit;
    for (int i = 0; i < cfg_lw[s]; i++)
      if (cfg_taps[s][6'(i)]) fb = fb ^ st[6'(i)];
    nst = st >> 1;
    nst[6'(cfg_lw[s] - 1)] = fb;
    return nst;
  endfunction

  task automatic m_seed(input int s, input logic [255:0] seed);
    m_st = seed[63:0] & ((64'd1 << cfg_lw[s]) - 64'd1);
    for (int k = cfg_lw[s]; k < cfg_sw[s]; k++) m_st = m_step(m_st, s, seed[8'(k)]);
    m_zf = (m_st == 64'd0);
    if (m_zf) m_st = cfg_init[s];
    for (int i = 0; i < cfg_wu[s]; i++) m_st = m_step(m_st, s, 1'b0);
  endtask

  function automatic logic [7:0] m_word(input int s);
    logic [7:0] w;
    w = 8'h00;
    for (int j = 0; j < cfg_ow[s]; j++) begin
      w[3'(j)] = m_st[0];
      m_st = m_step(m_st, s, 1'b0);
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sv(input int s, input logic v);
    case (s)
      0: sv_s = v;
      1: sv_b = v;
      default: sv_w = v;
    endcase
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic run_stream(input int s, input logic [255:0] seed, input int len,
                            input int stall_at, input int stall_len, input bit poke);
    int         lat, k, stalled, cyc, abs_cyc;
    logic       take;
    logic [7:0] exp_w;
    got.delete();
    m_seed(s, seed);
    abs_cyc   = cfg_sw[s] - cfg_lw[s];
    sel       = s;
    seed_bus  = seed;
    len_bus   = 16'(len);
    out_ready = 1'b1;
    set_sv(s, 1'b1);
    #1;
    check("seed_ready in idle", 64'(cur_ready), 64'd1);
    @(posedge clk); #1;
    set_sv(s, 1'b0);
    check("zero_fix cleared on accept", 64'(cur_zf), 64'd0);
    lat = 0;
    if (len == 0) begin
      while (!cur_done && lat < 1000) begin @(posedge clk); #1; lat++; end
      check("len0 done latency", 64'(lat), 64'(1 + abs_cyc + cfg_wu[s]));
      check("len0 no out_valid", 64'(cur_valid), 64'd0);
      @(posedge clk); #1;
      check("len0 done one cycle", 64'(cur_done), 64'd0);
    end else begin
      while (!cur_valid && lat < 1000) begin @(posedge clk); #1; lat++; end
      check("first out_valid latency", 64'(lat), 64'(2 + abs_cyc + cfg_wu[s]));
      check("zero_fix after seeding", 64'(cur_zf), 64'(m_zf));
      exp_w = m_word(s);
      k = 0; stalled = 0; cyc = 0;
      while (k < len && cyc < 4 * len + 100) begin
        if (k == stall_at && stalled < stall_len) begin
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
        end
        set_sv(s, poke && k == 1);
        seed_bus = (poke && k == 1) ? ~seed : seed;
        #1;
        if (poke && k == 1) check("seed_ready low in run", 64'(cur_ready), 64'd0);
        check("out_valid in stream", 64'(cur_valid), 64'd1);
        check("out_data word", 64'(cur_data), 64'(exp_w));
        take = out_ready && cur_valid;
        if (take) got.push_back(cur_data);
        @(posedge clk); #1;
        cyc++;
        if (take) begin
          k++;
          if (k < len) exp_w = m_word(s);
        end
      end
      set_sv(s, 1'b0);
      out_ready = 1'b1;
      check("words delivered", 64'(k), 64'(len));
      check("done after last word", 64'(cur_done), 64'd1);
      check("out_valid cleared at done", 64'(cur_valid), 64'd0);
      check("seed_ready back at done", 64'(cur_ready), 64'd1);
      @(posedge clk); #1;
      check("done one cycle", 64'(cur_done), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; sv_s = 1'b0; sv_b = 1'b0; sv_w = 1'b0;
    out_ready = 1'b1; seed_bus = '0; len_bus = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset seed_ready", 64'(sr_s), 64'd1);
    check("reset out_valid", 64'(ov_s), 64'd0);
    check("reset out_data", 64'(od_s), 64'd0);
    check("reset done", 64'(dn_s), 64'd0);
    check("reset zero_fix", 64'(zf_s), 64'd0);
    check("reset big seed_ready", 64'(sr_b), 64'd1);
    rst = 1'b0;

    // seed=1: words 0x01, 0x00
    run_stream(0, 256'h1, 2, -1, 0, 1'b0);
    check("seed1 word0 hand", 64'(got[0]), 64'h01);
    check("seed1 word1 hand", 64'(got[1]), 64'h00);

    // All-zero seed: INIT substituted, same stream as seed=1
    run_stream(0, 256'h0, 2, -1, 0, 1'b0);
    check("zero seed word0 hand", 64'(got[0]), 64'h01);
    check("zero seed word1 hand", 64'(got[1]), 64'h00);
    check("zero_fix sticky after done", 64'(cur_zf), 64'd1);

    // Backpressure mid-stream plus ignored seed_valid during RUN
    run_stream(0, 256'hDEADBEEF, 20, 6, 5, 1'b1);
    run_stream(0, 256'h0000A5A5, 0, -1, 0, 1'b0);

    // Default configuration: 224 absorb cycles
    run_stream(1, rand256(), 100, -1, 0, 1'b0);
    run_stream(1, rand256(), 100, 40, 5, 1'b1);
    run_stream(1, 256'h0, 3, -1, 0, 1'b0);
    check("big zero seed word0 hand", 64'(got[0]), 64'h01);

    // Reset during ABSORB, then a fresh seed
    sel = 1; seed_bus = rand256(); len_bus = 16'd50; sv_b = 1'b1;
    @(posedge clk); #1;
    sv_b = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst mid absorb seed_ready", 64'(sr_b), 64'd1);
    check("rst mid absorb out_valid", 64'(ov_b), 64'd0);
    run_stream(1, rand256(), 10, 3, 4, 1'b0);

    // Narrow LFSR with warm-up and 5-bit words
    run_stream(2, rand256(), 12, 4, 3, 1'b1);
    run_stream(2, rand256(), 0, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
